md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit in the EX stage of the pipelined MIPS CPU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the ID/EX pipeline register and holds the architectural HI/LO registers.
- Drives `hi`/`lo` into the EX-stage 32-bit result mux.
- Asserts `busy` so the hazard unit stalls any following MD instruction.

Parameters:
MULT_CYCLES, 5, cycles busy is held high for MULT/MULTU (minimum 1)
DIV_CYCLES, 10, cycles busy is held high for DIV/DIVU (minimum 1)

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  qualifies op/a/b this cycle
op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE
a  input  32  rs operand (multiplicand, dividend, or MTHI/MTLO source)
b  input  32  rt operand (multiplier or divisor)
busy  output  1  operation in flight; high for the full latency
hi  output  32  architectural HI register
lo  output  32  architectural LO register

Behaviour:
Reset:
- When `reset`=1 at an edge: hi=0, lo=0, busy=0, counter=0, pending result discarded.
- Reset has priority over every other input, including mid-operation.

Acceptance:
- An op is accepted only on an edge where start=1, busy=0 and the op is valid.
- start=1 while busy=1 is ignored: no state change, latency not extended.
- op 0 or 7 with start=1 is a no-op.

MTHI/MTLO:
- Written at the accepting edge: hi<=a or lo<=a.
- busy stays 0; the new value is visible the next cycle.

MULT/MULTU/DIV/DIVU:
- At the accepting edge, the 64-bit result is computed from a/b and latched into a pending {hi_n, lo_n} register.
- Counter is loaded with N (MULT_CYCLES or DIV_CYCLES).
- busy = (counter != 0). It is high for exactly N cycles following the accepting edge.
- Each edge with counter != 0 decrements the counter.
- On the edge where the counter goes 1->0, hi/lo take the pending values and busy falls. Old hi/lo stay visible until that edge.

Arithmetic:
- MULT: signed 32x32 -> 64 product; HI = [63:32], LO = [31:0].
- MULTU: same, unsigned.
- DIV: signed division truncating toward zero; LO = quotient, HI = remainder. The remainder takes the dividend's sign.
- 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: unsigned division.
- Divisor 0 (DIV or DIVU): busy runs the full DIV_CYCLES; hi/lo remain unchanged at completion.

Other rules:
- The state machine has two states: IDLE (counter=0) and BUSY (counter>0). There are no other states.
- The result computation may be combinational at acceptance; the cycle count is architectural regardless of the internal datapath.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5, start 1 cycle -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1. During busy, hi/lo show the prior values.
- MULTU a=0xFFFFFFFF, b=2 -> after 5 busy cycles, hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=7, b=0 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO -> busy 10 cycles; hi=0x11, lo=0x22 unchanged.
- Start DIVU 100/7, then on busy cycle 3 issue MTLO a=0xABCD and MULT -> both ignored; at completion lo=14, hi=2.
- Start DIV, assert reset on busy cycle 4 -> next cycle busy=0, hi=0, lo=0. No late write-back occurs in the following 10 cycles.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit holding the architectural HI/LO
// registers. The 64-bit result is formed combinationally at acceptance and
// parked in a pending register. It is written to HI/LO when the latency
// counter expires, so the visible cycle count stays fixed regardless of
// the datapath.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_NONE7 = 3'd7
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    md_op_e      op_e;
    state_e      state, next_state;
    logic [CW-1:0] count, next_count;
    logic        accept_long;
    logic        wr_hi_now;
    logic        wr_lo_now;
    logic        finish;

    logic [63:0] result;
    logic        result_valid;
    logic [31:0] pend_hi, pend_lo;
    logic        pend_we;

    assign op_e = md_op_e'(op);
    assign busy = (state == BUSY);

    // Latency counter and state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= next_state;
            count <= next_count;
        end
    end

    // Next-state logic: acceptance in IDLE, countdown in BUSY.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path can leave a value unassigned and infer a latch.
        next_state  = state;
        next_count  = count;
        accept_long = 1'b0;
        wr_hi_now   = 1'b0;
        wr_lo_now   = 1'b0;
        finish      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    case (op_e)
                        OP_MULT, OP_MULTU: begin
                            accept_long = 1'b1;
                            next_count  = CW'(MULT_CYCLES);
                            next_state  = BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            accept_long = 1'b1;
                            next_count  = CW'(DIV_CYCLES);
                            next_state  = BUSY;
                        end
                        OP_MTHI: wr_hi_now = 1'b1;
                        OP_MTLO: wr_lo_now = 1'b1;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                next_count = count - CW'(1);
                if (count == CW'(1)) begin
                    next_state = IDLE;
                    finish     = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Arithmetic datapath. Division uses operand magnitudes and then fixes
    // the signs: the quotient truncates toward zero and the remainder
    // follows the dividend. A zero divisor is replaced by 1 so the divider
    // never sees it; that result is discarded anyway.
    logic        is_signed_div;
    logic [31:0] abs_a, abs_b, dvd, dvs, q_mag, r_mag, quo, rem;

    always_comb begin
        is_signed_div = (op_e == OP_DIV);
        abs_a = a[31] ? (32'd0 - a) : a;
        abs_b = b[31] ? (32'd0 - b) : b;
        dvd   = is_signed_div ? abs_a : a;
        dvs   = is_signed_div ? abs_b : b;
        if (dvs == 32'd0) dvs = 32'd1;
        q_mag = dvd / dvs;
        r_mag = dvd % dvs;
        quo   = (is_signed_div && (a[31] ^ b[31])) ? (32'd0 - q_mag) : q_mag;
        rem   = (is_signed_div && a[31]) ? (32'd0 - r_mag) : r_mag;
    end

    // Result select; a zero divisor marks the result as not to be written.
    always_comb begin
        result       = 64'd0;
        result_valid = 1'b1;
        case (op_e)
            OP_MULT:  result = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            OP_MULTU: result = {32'd0, a} * {32'd0, b};
            OP_DIV, OP_DIVU: begin
                result       = {rem, quo};
                result_valid = (b != 32'd0);
            end
            default: ;
        endcase
    end

    // HI/LO and the pending result: immediate moves, capture at acceptance,
    // write-back at expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_we <= 1'b0;
        end else begin
            if (wr_hi_now) hi <= a;
            if (wr_lo_now) lo <= a;
            if (accept_long) begin
                pend_hi <= result[63:32];
                pend_lo <= result[31:0];
                pend_we <= result_valid;
            end
            if (finish && pend_we) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed vector table for md_unit plus hand-written sequences
// for ignored starts during busy and reset in the middle of an operation.
module tb_md_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cycles;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one start pulse; returns at the falling edge after the accepting edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
    endtask

    // Count busy samples from the current falling edge until busy drops (bounded).
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        logic [31:0] prev_hi, prev_lo;

        vecs[0]  = '{3'd5, 32'h12345678, 32'h0,        32'h12345678, 32'h00000000, 0};
        vecs[1]  = '{3'd6, 32'h9ABCDEF0, 32'h0,        32'h12345678, 32'h9ABCDEF0, 0};
        vecs[2]  = '{3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, MULT_N};
        vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, MULT_N};
        vecs[4]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_N};
        vecs[5]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_N};
        vecs[6]  = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_N};
        vecs[7]  = '{3'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, DIV_N};
        vecs[8]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MULT_N};
        vecs[9]  = '{3'd0, 32'hDEADBEEF, 32'd3,        32'h40000000, 32'h00000000, 0};
        vecs[10] = '{3'd7, 32'hDEADBEEF, 32'd3,        32'h40000000, 32'h00000000, 0};
        vecs[11] = '{3'd5, 32'h00000011, 32'h0,        32'h00000011, 32'h00000000, 0};
        vecs[12] = '{3'd6, 32'h00000022, 32'h0,        32'h00000011, 32'h00000022, 0};
        vecs[13] = '{3'd4, 32'd7,        32'd0,        32'h00000011, 32'h00000022, DIV_N};
        vecs[14] = '{3'd3, 32'hFFFFFFFB, 32'd0,        32'h00000011, 32'h00000022, DIV_N};
        vecs[15] = '{3'd2, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, MULT_N};

        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        prev_hi = 32'd0;
        prev_lo = 32'd0;
        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            if (vecs[i].cycles > 0) begin
                check($sformatf("v%0d_hold_hi", i), hi, prev_hi);
                check($sformatf("v%0d_hold_lo", i), lo, prev_lo);
            end
            wait_idle(n);
            check($sformatf("v%0d_busy_cycles", i), n, vecs[i].cycles);
            check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
            check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
            prev_hi = vecs[i].exp_hi;
            prev_lo = vecs[i].exp_lo;
        end

        // Starts during busy are ignored and do not stretch the latency.
        issue(3'd4, 32'd100, 32'd7);      // busy cycle 1 sampled here
        @(negedge clk);                   // busy cycle 2
        @(negedge clk);                   // busy cycle 3
        start = 1'b1;
        op    = 3'd6;
        a     = 32'h0000ABCD;
        b     = 32'd0;
        @(negedge clk);                   // busy cycle 4
        op    = 3'd1;
        a     = 32'd3;
        b     = 32'd3;
        @(negedge clk);                   // busy cycle 5
        start = 1'b0;
        op    = 3'd0;
        check("ign_lo_during_busy", lo, 32'h00000000);
        wait_idle(n);
        check("ign_busy_remaining", n, DIV_N - 4);
        check("ign_hi", hi, 32'd2);
        check("ign_lo", lo, 32'd14);
        @(negedge clk);
        check("ign_no_late_mult", {31'd0, busy}, 32'd0);

        // Reset in the middle of a divide discards the pending result.
        issue(3'd3, 32'd100, 32'd7);      // busy cycle 1
        repeat (3) @(negedge clk);        // busy cycle 4
        check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("rst_quiet%0d_busy", k), {31'd0, busy}, 32'd0);
            check($sformatf("rst_quiet%0d_hi", k), hi, 32'd0);
            check($sformatf("rst_quiet%0d_lo", k), lo, 32'd0);
        end

        // Unit still works after the mid-operation reset.
        issue(3'd1, 32'd6, 32'd7);
        wait_idle(n);
        check("post_rst_cycles", n, MULT_N);
        check("post_rst_hi", hi, 32'd0);
        check("post_rst_lo", lo, 32'd42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
